// File: rtl/a2s_conv_scheduler.sv
// rtl/a2s_conv_scheduler.sv - round-robin scheduler sharing one ANN-to-SNN rate converter among NUM_CH channels; optional WAIT watchdog via A2S_SCHED_WATCHDOG_EN
module a2s_conv_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int T           = 4,
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int WDOG_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]        conv_data_in,
    output logic                         conv_data_valid,
    input  logic [T-1:0]                 conv_spike_out,
    input  logic                         conv_spike_valid,
    output logic                         rsp_valid,
    output logic [T-1:0]                 rsp_spikes,
    output logic [CH_W-1:0]              rsp_ch,
    input  logic                         rsp_ready,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int CNT_W = $clog2(T + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_FEED,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CH_W-1:0]         rr_ptr_q;
    logic [CH_W-1:0]         grant_q;
    logic [CNT_W-1:0]        word_cnt_q;
    logic [CH_W-1:0]         cand;
    logic [CH_W-1:0]         pick;
    logic                    found;
    logic                    grant_en;
    logic                    word_xfer;
    logic                    last_word;
    logic                    capture;
    logic                    rsp_done;
    logic                    wdog_fire;
    logic [DATA_WIDTH-1:0]   ch_word [NUM_CH];

    if (NUM_CH < 2 || T < 1 || DATA_WIDTH < 1 || WDOG_CYCLES < 1) begin : g_bad_params
        $error("a2s_conv_scheduler: illegal parameter value");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch_word
        assign ch_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign last_word = (word_cnt_q == CNT_W'(T - 1));
    assign busy      = (state_q != S_IDLE);

    // Round-robin search: first requesting channel starting just after the last grant
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and converter/request-side outputs
    always_comb begin
        state_d         = state_q;
        req_ready       = '0;
        conv_data_valid = 1'b0;
        conv_data_in    = '0;
        grant_en        = 1'b0;
        word_xfer       = 1'b0;
        capture         = 1'b0;
        rsp_done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_en = 1'b1;
                    state_d  = S_PRIME;
                end
            end
            S_PRIME: begin
                // Zero-data strobe only wakes the converter into LOAD
                conv_data_valid = 1'b1;
                state_d         = S_FEED;
            end
            S_FEED: begin
                req_ready[grant_q] = 1'b1;
                conv_data_in       = ch_word[grant_q];
                conv_data_valid    = req_valid[grant_q];
                word_xfer          = req_valid[grant_q];
                if (word_xfer && last_word) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (conv_spike_valid) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end else if (wdog_fire) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Converter must be back in IDLE before the next PRIME
                if (!conv_spike_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant, word counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= CH_W'(NUM_CH - 1);
            grant_q    <= '0;
            word_cnt_q <= '0;
            rsp_valid  <= 1'b0;
            rsp_spikes <= '0;
            rsp_ch     <= '0;
        end else begin
            if (grant_en) begin
                grant_q  <= pick;
                rr_ptr_q <= pick;
            end
            if (word_xfer) begin
                word_cnt_q <= last_word ? '0 : word_cnt_q + CNT_W'(1);
            end
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_spikes <= conv_spike_out;
                rsp_ch     <= grant_q;
            end else if (rsp_done) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

`ifdef A2S_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    assign wdog_fire   = (state_q == S_WAIT) && (wdog_q == WD_W'(WDOG_CYCLES - 1));
    assign err_timeout = err_q;

    // Cycles spent in WAIT; held at zero elsewhere so it is clear on WAIT entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != S_WAIT || conv_spike_valid || wdog_fire) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WD_W'(1);
            end
            if (wdog_fire && !conv_spike_valid) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wdog_fire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_a2s_conv_scheduler.sv
// tb/tb_a2s_conv_scheduler.sv - scoreboard bench for a2s_conv_scheduler with converter stub and round-robin reference model
module tb_a2s_conv_scheduler;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int T      = 4;
    localparam int CH_W   = 2;
    localparam int WDOG   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_CH-1:0]      req_valid;
    logic [NUM_CH*DW-1:0]   req_data;
    logic [NUM_CH-1:0]      req_ready;
    logic [DW-1:0]          conv_data_in;
    logic                   conv_data_valid;
    logic [T-1:0]           conv_spike_out;
    logic                   conv_spike_valid;
    logic                   rsp_valid;
    logic [T-1:0]           rsp_spikes;
    logic [CH_W-1:0]        rsp_ch;
    logic                   rsp_ready;
    logic                   busy;
    logic                   err_timeout;

    a2s_conv_scheduler #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .T(T), .CH_W(CH_W), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .conv_data_in(conv_data_in), .conv_data_valid(conv_data_valid),
        .conv_spike_out(conv_spike_out), .conv_spike_valid(conv_spike_valid),
        .rsp_valid(rsp_valid), .rsp_spikes(rsp_spikes), .rsp_ch(rsp_ch),
        .rsp_ready(rsp_ready), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // channel sources
    logic [DW-1:0]     chq [NUM_CH][$];
    int                pos [NUM_CH];
    int                stall [NUM_CH];
    bit                xfer [NUM_CH];
    int                stall_pct = 0;
    int                force_ch = -1;
    int                force_after = 0;
    int                force_len = 0;
    int                rdy_mode = 0;
    int                bursts_done = 0;

    // reference model
    logic [T*DW-1:0]   mq [NUM_CH][$];
    int                m_rr = NUM_CH - 1;
    logic [CH_W+T-1:0] exp_q [$];

    // converter stub
    int                c_state = 0;
    int                c_n = 0;
    int                c_lat = 0;
    int                c_hold = 0;
    logic [T*DW-1:0]   c_words = '0;
    logic [T-1:0]      c_spk = '0;
    bit                never_spike = 0;

    // observation counters
    int                dv_cnt = 0;
    int                stall_obs = 0;
    int                rr_cnt [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rate coding: membrane starts at 4, threshold 8, subtract on spike; word k -> timestep k
    function automatic logic [T-1:0] rate(input logic [T*DW-1:0] b);
        int mem;
        logic [T-1:0] s;
        mem = 4;
        s = '0;
        for (int t = 0; t < T; t++) begin
            mem += int'(b[t*DW +: DW]);
            if (mem >= 8) begin
                s[t] = 1'b1;
                mem -= 8;
            end
        end
        return s;
    endfunction

    task automatic add_burst(input int c, input logic [T*DW-1:0] b);
        for (int k = 0; k < T; k++) chq[c].push_back(b[k*DW +: DW]);
        mq[c].push_back(b);
    endtask

    // Grants go to the next pending channel after the previous grant, one burst each
    task automatic commit();
        bit any;
        logic [T*DW-1:0] b;
        any = 1;
        while (any) begin
            any = 0;
            for (int i = 1; i <= NUM_CH; i++) begin
                int c;
                c = (m_rr + i) % NUM_CH;
                if (!any && mq[c].size() != 0) begin
                    b = mq[c].pop_front();
                    exp_q.push_back({CH_W'(c), rate(b)});
                    m_rr = c;
                    any = 1;
                end
            end
        end
    endtask

    task automatic flush_all();
        for (int c = 0; c < NUM_CH; c++) begin
            chq[c].delete();
            mq[c].delete();
            pos[c] = 0;
            stall[c] = 0;
            xfer[c] = 0;
        end
        exp_q.delete();
        m_rr = NUM_CH - 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_spikes"}, rsp_spikes, 0);
        check({tag, "_rsp_ch"}, rsp_ch, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_conv_dv"}, conv_data_valid, 0);
        check({tag, "_conv_din"}, conv_data_in, 0);
        check({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        flush_all();
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0) || busy;
        for (int c = 0; c < NUM_CH; c++) if (chq[c].size() != 0) p = 1;
        return p;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({name, "_completes"}, (n < budget), 1);
    endtask

    // Channel drivers and response-ready generator
    initial begin
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            pos[c] = 0; stall[c] = 0; xfer[c] = 0; rr_cnt[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (xfer[c]) begin
                    void'(chq[c].pop_front());
                    pos[c] = (pos[c] + 1) % T;
                    if (pos[c] == 0) bursts_done++;
                    else if (c == force_ch && pos[c] == force_after) stall[c] = force_len;
                    else if (int'($urandom_range(99)) < stall_pct) stall[c] = $urandom_range(3, 1);
                end
                xfer[c] = 0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (stall[c] > 0) begin
                    req_valid[c] = 1'b0;
                    req_data[c*DW +: DW] = DW'($urandom);
                    stall[c]--;
                end else if (chq[c].size() != 0) begin
                    req_valid[c] = 1'b1;
                    req_data[c*DW +: DW] = chq[c][0];
                end else begin
                    req_valid[c] = 1'b0;
                    req_data[c*DW +: DW] = DW'($urandom);
                end
            end
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(1));
                default: rsp_ready = 1'b0;
            endcase
            #1;
            for (int c = 0; c < NUM_CH; c++) xfer[c] = rst_n && req_valid[c] && req_ready[c];
        end
    end

    // Converter stub: IDLE -> LOAD on priming strobe, T words, latency, spike train held 1..3 cycles
    initial begin
        conv_spike_valid = 1'b0;
        conv_spike_out   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) c_state = 0;
            conv_spike_valid = (c_state == 3);
            conv_spike_out   = (c_state == 3) ? c_spk : '0;
            if (c_state == 3) begin
                if (c_hold <= 1) c_state = 0;
                else c_hold--;
            end
            #1;
            if (!rst_n) begin
                c_state = 0;
            end else begin
                case (c_state)
                    0: if (conv_data_valid) begin c_state = 1; c_n = 0; end
                    1: if (conv_data_valid) begin
                        c_words[c_n*DW +: DW] = conv_data_in;
                        c_n++;
                        if (c_n == T) begin
                            c_spk = rate(c_words);
                            c_lat = $urandom_range(3);
                            c_state = 2;
                        end
                    end
                    2: if (!never_spike) begin
                        if (c_lat == 0) begin c_state = 3; c_hold = $urandom_range(3, 1); end
                        else c_lat--;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: interface invariants, response hold and scoreboard comparison
    initial begin
        bit               held;
        logic [T-1:0]     h_sp;
        logic [CH_W-1:0]  h_ch;
        logic [CH_W+T-1:0] e;
        held = 0; h_sp = '0; h_ch = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 0;
                continue;
            end
            check("req_ready_onehot0", $onehot0(req_ready), 1);
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_ready[c]) begin
                    rr_cnt[c]++;
                    check("feed_valid_follows", conv_data_valid, req_valid[c]);
                    if (req_valid[c]) check("feed_data", conv_data_in, req_data[c*DW +: DW]);
                    else stall_obs++;
                end
            end
            if (conv_data_valid) dv_cnt++;
            if (conv_data_valid && req_ready == '0) begin
                check("prime_data_zero", conv_data_in, 0);
                check("prime_conv_quiet", conv_spike_valid, 0);
                check("prime_no_rsp", rsp_valid, 0);
            end
            if (held) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_spikes", rsp_spikes, h_sp);
                check("rsp_hold_ch", rsp_ch, h_ch);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=ch%0d/%b required=none", rsp_ch, rsp_spikes);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_ch", rsp_ch, e[CH_W+T-1:T]);
                    check("rsp_spikes", rsp_spikes, e[T-1:0]);
                end
            end
            held = rsp_valid && !rsp_ready;
            h_sp = rsp_spikes;
            h_ch = rsp_ch;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("por");
        do_reset();

        // Directed burst: 3,3,3,3 on channel 0 gives 4'b1010
        for (int k = 0; k < T; k++) chq[0].push_back(8'd3);
        exp_q.push_back({2'd0, 4'b1010});
        m_rr = 0;
        dv_cnt = 0;
        rr_cnt[0] = 0;
        wait_done("single", 200);
        check("single_dv_cycles", dv_cnt, T + 1);
        check("single_ready_cycles", rr_cnt[0], T);

        // Channels 0 and 2 requesting from reset: grants alternate 0,2,0,2
        do_reset();
        for (int r = 0; r < 2; r++) begin
            add_burst(0, (T*DW)'($urandom));
            add_burst(2, (T*DW)'($urandom));
        end
        commit();
        rr_cnt[1] = 0;
        rr_cnt[3] = 0;
        wait_done("alt02", 400);
        check("alt02_ch1_never_ready", rr_cnt[1], 0);
        check("alt02_ch3_never_ready", rr_cnt[3], 0);

        // Channel 1 stalls 3 cycles after its 2nd word
        force_ch = 1; force_after = 2; force_len = 3;
        add_burst(1, (T*DW)'($urandom));
        commit();
        dv_cnt = 0;
        stall_obs = 0;
        wait_done("stall", 200);
        check("stall_dv_cycles", dv_cnt, T + 1);
        check("stall_low_cycles", stall_obs, 3);
        force_ch = -1;

        // Response back-pressure for 5 cycles with another channel waiting
        rdy_mode = 2;
        add_burst(3, (T*DW)'($urandom));
        add_burst(0, (T*DW)'($urandom));
        commit();
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("bp_rsp_seen", (n < 200), 1);
        repeat (5) begin
            @(negedge clk);
            #3;
            check("bp_no_grant", req_ready, 0);
            check("bp_no_feed", conv_data_valid, 0);
            check("bp_busy", busy, 1);
        end
        rdy_mode = 0;
        wait_done("bp", 400);

        // Reset after the 2nd word abandons the burst; a fresh burst then completes
        add_burst(2, (T*DW)'($urandom));
        n = 0;
        while (pos[2] != 2 && n < 200) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("midrst_reached", (n < 200), 1);
        rst_n = 1'b0;
        flush_all();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        add_burst(2, (T*DW)'($urandom));
        commit();
        wait_done("midrst_fresh", 200);

        // Randomized rounds
        stall_pct = 25;
        rdy_mode = 1;
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                int nb;
                nb = $urandom_range(2);
                for (int b = 0; b < nb; b++) add_burst(c, (T*DW)'($urandom));
            end
            commit();
            wait_done("random", 3000);
        end
        stall_pct = 0;
        rdy_mode = 0;

`ifdef A2S_SCHED_WATCHDOG_EN
        // Converter never answers: timeout exactly WDOG cycles after WAIT entry, no response
        do_reset();
        never_spike = 1;
        n = bursts_done;
        add_burst(1, (T*DW)'($urandom));
        begin
            int w;
            w = 0;
            while (bursts_done == n && w < 200) begin
                @(negedge clk);
                #3;
                w++;
            end
            check("wdog_burst_fed", (w < 200), 1);
            w = 0;
            while (!err_timeout && w < 4 * WDOG) begin
                @(negedge clk);
                #3;
                w++;
                if (!err_timeout) check("wdog_no_rsp", rsp_valid, 0);
            end
            check("wdog_timeout_cycle", w, WDOG);
        end
        mq[1].delete();
        wait_done("wdog_idle", 100);
        check("wdog_sticky", err_timeout, 1);
        never_spike = 0;
        do_reset();
`else
        check("err_timeout_tied", err_timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
